// File: rtl/sorter_pkg.sv
// sorter_pkg: sizing and FSM encoding shared by the merge sorter result path.
package sorter_pkg;
    localparam int W = 32;
    localparam int N_WORDS = 128;
    localparam int CNT_W = 8;
    typedef enum logic [1:0] {IDLE, COLLECT, STREAM, DONE} state_e;
endpackage

// File: rtl/result_buffer.sv
// result_buffer: simple dual-port RAM with synchronous write and registered read.
module result_buffer #(
    parameter int W = 32,
    parameter int DEPTH = 128,
    parameter int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);
    logic [W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    // Only the read register is reset; the array itself holds no meaningful state between jobs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rdata <= '0;
        else if (re) rdata <= mem[raddr];
    end
endmodule

// File: rtl/sort_result_collector.sv
// sort_result_collector: pops one sorted job from the tree root, checks ascending order,
// buffers it and streams it out over valid/ready.
module sort_result_collector #(
    parameter int W = sorter_pkg::W,
    parameter int N_WORDS = sorter_pkg::N_WORDS,
    parameter int CNT_W = sorter_pkg::CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [W-1:0]     t_dout,
    input  logic             t_empty,
    output logic             t_deq,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [W-1:0]     rd_data,
    output logic             rd_last,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] word_cnt,
    output logic             order_err,
    output logic [CNT_W-1:0] err_idx
);
    import sorter_pkg::*;
    localparam int AW = $clog2(N_WORDS);
    localparam logic [CNT_W-1:0] N = CNT_W'(N_WORDS);
    state_e state_q, state_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d, err_idx_q, err_idx_d, rd_ptr_q, rd_ptr_d;
    logic [W-1:0] prev_q, prev_d;
    logic order_err_q, order_err_d, done_q, done_d;
    logic rd_valid_q, rd_valid_d, rd_last_q, rd_last_d;
    logic re, fire, bad;
    always_comb begin
        t_deq = state_q == COLLECT && !t_empty && word_cnt_q < N;
        fire = rd_valid_q && rd_ready;
        // Refill the output register when it is empty or being drained this cycle.
        re = state_q == STREAM && (!rd_valid_q || fire) && rd_ptr_q < N;
        bad = word_cnt_q != '0 && t_dout < prev_q && !order_err_q;
        state_d = state_q;
        word_cnt_d = word_cnt_q;
        err_idx_d = err_idx_q;
        rd_ptr_d = rd_ptr_q;
        prev_d = prev_q;
        order_err_d = order_err_q;
        done_d = done_q;
        rd_valid_d = rd_valid_q;
        rd_last_d = rd_last_q;
        if (state_q == IDLE && start) begin
            state_d = COLLECT;
            word_cnt_d = '0;
            done_d = 1'b0;
            order_err_d = 1'b0;
            err_idx_d = '0;
        end
        if (t_deq) begin
            word_cnt_d = word_cnt_q + 1'b1;
            prev_d = t_dout;
            order_err_d = order_err_q | bad;
            err_idx_d = bad ? word_cnt_q : err_idx_q;
            if (word_cnt_q == N - 1'b1) begin
                state_d = STREAM;
                rd_ptr_d = '0;
            end
        end
        if (re) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            rd_valid_d = 1'b1;
            rd_last_d = rd_ptr_q == N - 1'b1;
        end else if (fire) begin
            rd_valid_d = 1'b0;
            rd_last_d = 1'b0;
        end
        if (fire && rd_last_q) begin
            state_d = DONE;
            done_d = 1'b1;
        end
        if (state_q == DONE) state_d = IDLE;
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_cnt_q <= '0;
            err_idx_q <= '0;
            rd_ptr_q <= '0;
            prev_q <= '0;
            order_err_q <= 1'b0;
            done_q <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            word_cnt_q <= word_cnt_d;
            err_idx_q <= err_idx_d;
            rd_ptr_q <= rd_ptr_d;
            prev_q <= prev_d;
            order_err_q <= order_err_d;
            done_q <= done_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q <= rd_last_d;
        end
    end
    result_buffer #(.W(W), .DEPTH(N_WORDS), .AW(AW)) u_buf (
        .clk(clk),
        .rst(rst),
        .we(t_deq),
        .waddr(word_cnt_q[AW-1:0]),
        .wdata(t_dout),
        .re(re),
        .raddr(rd_ptr_q[AW-1:0]),
        .rdata(rd_data)
    );
    assign rd_valid = rd_valid_q;
    assign rd_last = rd_last_q;
    assign busy = state_q != IDLE;
    assign done = done_q;
    assign word_cnt = word_cnt_q;
    assign order_err = order_err_q;
    assign err_idx = err_idx_q;
endmodule

// File: tb/tb_sort_result_collector.sv
// tb_sort_result_collector: tree model feeding the collector, scoreboard on the output stream.
module tb_sort_result_collector;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [31:0] t_dout;
    logic t_empty, t_deq, rd_valid, rd_last, busy, done, order_err;
    logic rd_ready = 1'b1;
    logic [31:0] rd_data;
    logic [7:0] word_cnt, err_idx;
    logic [31:0] tree_mem [256];
    int tr_idx, tr_len = 0, stall_cnt;
    logic tr_clr = 1'b0, stall_en = 1'b0, rnd_ready = 1'b0;
    logic [31:0] exp_q [$];
    int n_chk = 0, n_err = 0;
    int xfers, deq_cyc, empty_deq, collect_cyc, stray_deq;
    logic held, lat_pend;
    logic [31:0] held_d;
    logic [7:0] wc_prev;

    sort_result_collector dut (
        .clk(clk), .rst(rst), .start(start), .t_dout(t_dout), .t_empty(t_empty),
        .t_deq(t_deq), .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .rd_last(rd_last), .busy(busy), .done(done), .word_cnt(word_cnt),
        .order_err(order_err), .err_idx(err_idx)
    );

    always #5 clk = ~clk;

    assign t_dout = tree_mem[tr_idx[7:0]];
    assign t_empty = stall_cnt != 0 || tr_idx >= tr_len;

    // Tree root model: shares the collector reset, optionally goes empty for 5 cycles after every 16 pops.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            tr_idx <= 0;
            stall_cnt <= 0;
        end else if (tr_clr) begin
            tr_idx <= 0;
            stall_cnt <= 0;
        end else begin
            if (t_deq) tr_idx <= tr_idx + 1;
            if (t_deq && stall_en && (tr_idx + 1) % 16 == 0 && tr_idx + 1 < 128) stall_cnt <= 5;
            else if (stall_cnt != 0) stall_cnt <= stall_cnt - 1;
        end
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string pfx);
        chk({pfx, "_t_deq"}, t_deq, 0);
        chk({pfx, "_rd_valid"}, rd_valid, 0);
        chk({pfx, "_rd_last"}, rd_last, 0);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_order_err"}, order_err, 0);
        chk({pfx, "_word_cnt"}, word_cnt, 0);
        chk({pfx, "_err_idx"}, err_idx, 0);
        chk({pfx, "_rd_data"}, rd_data, 0);
    endtask

    function automatic logic [31:0] word_val(input int kind, input int i);
        if (kind == 1) begin
            if (i < 49) return 32'h10;
            if (i == 49) return 32'h20;
            if (i == 50) return 32'h10;
            if (i < 90) return 32'h100 + 32'(i);
            if (i == 90) return 32'h5;
            return 32'h200 + 32'(i);
        end
        if (kind == 2) return 32'(i * 3 + 7);
        return 32'(i);
    endfunction

    task automatic load_tree(input int kind, input int len, input bit push);
        for (int i = 0; i < len; i++) begin
            tree_mem[i] = word_val(kind, i);
            if (push && i < 128) exp_q.push_back(tree_mem[i]);
        end
        tr_len = len;
        tr_clr = 1'b1;
        @(negedge clk);
        tr_clr = 1'b0;
    endtask

    // One negedge sample: drive rd_ready for the coming edge, then score the outputs.
    task automatic sample();
        rd_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        if (t_deq) deq_cyc++;
        if (t_deq && t_empty) empty_deq++;
        if (busy && word_cnt < 128) collect_cyc++;
        else if (t_deq) stray_deq++;
        if (held) chk("hold", {rd_valid, rd_data}, {1'b1, held_d});
        held = rd_valid && !rd_ready;
        held_d = rd_data;
        if (rd_valid && rd_ready) begin
            chk("last", rd_last, xfers == 127);
            if (exp_q.size() == 0) chk("sb_empty", exp_q.size(), 1);
            else chk("data", rd_data, exp_q.pop_front());
            xfers++;
        end
        if (lat_pend) chk("valid_lat1", rd_valid, 1);
        lat_pend = 1'b0;
        if (word_cnt == 128 && wc_prev != 128) begin
            chk("valid_lat0", rd_valid, 0);
            lat_pend = 1'b1;
        end
        wc_prev = word_cnt;
    endtask

    task automatic run_job(input int kind, input bit stall, input bit rnd, input bit pokes, input int len);
        exp_q.delete();
        load_tree(kind, len, 1'b1);
        stall_en = stall;
        rnd_ready = rnd;
        xfers = 0; deq_cyc = 0; empty_deq = 0; collect_cyc = 0; stray_deq = 0;
        held = 1'b0; lat_pend = 1'b0; wc_prev = word_cnt;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 4000 && !done; c++) begin
            sample();
            start = pokes && (word_cnt == 40 || xfers == 20);
            @(negedge clk);
        end
        start = 1'b0;
        rd_ready = 1'b1;
        chk("done", done, 1);
        chk("order_err", order_err, kind == 1);
        chk("err_idx", err_idx, kind == 1 ? 50 : 0);
        chk("xfers", xfers, 128);
        chk("pops", tr_idx, 128);
        chk("sb_left", exp_q.size(), 0);
        chk("word_cnt", word_cnt, 128);
        chk("deq_cyc", deq_cyc, 128);
        chk("collect_cyc", collect_cyc, stall ? 163 : 128);
        chk("empty_deq", empty_deq, 0);
        chk("stray_deq", stray_deq, 0);
        @(negedge clk);
        chk("idle_busy", busy, 0);
        chk("done_hold", done, 1);
        chk("rd_valid_off", rd_valid, 0);
        @(negedge clk);
        chk("idle_deq", t_deq, 0);
        chk("idle_pops", tr_idx, 128);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("rst0");
        rst = 1'b0;
        @(negedge clk);
        run_job(0, 1'b0, 1'b0, 1'b0, 128);
        run_job(0, 1'b1, 1'b0, 1'b0, 128);
        run_job(1, 1'b0, 1'b0, 1'b0, 128);
        run_job(0, 1'b0, 1'b1, 1'b0, 128);
        load_tree(0, 128, 1'b0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 500 && word_cnt != 60; c++) @(negedge clk);
        chk("mid_cnt", word_cnt, 60);
        rst = 1'b1;
        #1;
        chk_reset("rst_mid");
        chk("rst_tree", tr_idx, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_job(2, 1'b0, 1'b0, 1'b0, 128);
        run_job(0, 1'b0, 1'b0, 1'b1, 130);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/sort_result_collector.md
Name: sort_result_collector

Overview:
- Downstream stage of the merge sorter tree.
- Pops exactly N_WORDS sorted words from the tree root, checks ascending order on the fly, and stores them in a local buffer.
- Then streams the buffer out over a valid/ready interface.
- Replaces the ad-hoc dequeue/finished logic previously held in simulation control code with synthesizable RTL.

Parameters:
- W, 32, data word width (matches tree dout).
- N_WORDS, 128, words per sort job.
- CNT_W, 8, counter width; must satisfy 2^CNT_W > N_WORDS.

Ports:
- clk  in  1  system clock, posedge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle pulse; begins collection of a new job.
- t_dout  in  W  tree root head word; valid whenever t_empty=0.
- t_empty  in  1  tree root empty.
- t_deq  out  1  pop tree root this cycle.
- rd_valid  out  1  stream output word valid.
- rd_ready  in  1  downstream accepts word.
- rd_data  out  W  stream output word.
- rd_last  out  1  marks word index N_WORDS-1.
- busy  out  1  state != IDLE.
- done  out  1  all words streamed; held until next start.
- word_cnt  out  CNT_W  words collected in the current job.
- order_err  out  1  sticky; a descending pair was detected this job.
- err_idx  out  CNT_W  index of the first word that violated order.

Behaviour:
- Reset: state=IDLE; t_deq, rd_valid, rd_last, busy, done, order_err=0; word_cnt, err_idx, rd_data=0. Buffer contents are not reset.
- State IDLE:
  - start=1 -> COLLECT; clear word_cnt, done, order_err, err_idx.
  - Otherwise hold; done keeps its value.
- State COLLECT:
  - t_deq = !t_empty && word_cnt < N_WORDS. Combinational, no latency.
  - On a clock edge with t_deq=1: buf[word_cnt] <= t_dout; prev <= t_dout; word_cnt++.
  - Order check applies for word_cnt>0 only, unsigned compare: if t_dout < prev and order_err==0, set order_err=1 and err_idx=word_cnt. Equal values are legal.
  - When the pop of word N_WORDS-1 occurs -> STREAM, with rd_ptr=0 and a buffer read issued.
  - t_empty=1 stalls indefinitely; no timeout.
- State STREAM:
  - Buffer read is registered. rd_valid rises exactly 1 cycle after entering STREAM.
  - Handshake: word transfers on rd_valid && rd_ready.
  - rd_data and rd_valid stay stable while rd_ready=0.
  - On transfer, the next word appears the following cycle (prefetch allowed), so full throughput is 1 word per cycle with rd_ready tied high.
  - rd_last=1 together with word N_WORDS-1.
  - The transfer with rd_last -> DONE; rd_valid drops next cycle.
- State DONE: done=1; next cycle -> IDLE with done held at 1.
- Boundary and simultaneous cases:
  - start while busy: ignored.
  - start in the same cycle done is set: ignored. Start is honoured only from IDLE.
  - t_deq is never asserted outside COLLECT, and never beyond N_WORDS pops, even if the tree is non-empty.
  - word_cnt saturates at N_WORDS.
  - rst mid-job: immediate return to IDLE with all outputs at reset values. A partially popped tree must be reset by the same rst.
- Width rules:
  - Counters are CNT_W bits wide.
  - Comparisons are unsigned on W bits.
  - No arithmetic on data.

Decomposition:
- Shared package (sorter_pkg): W, N_WORDS, CNT_W; state encoding enum {IDLE, COLLECT, STREAM, DONE}.
- One natural sub-module: result_buffer, a simple dual-port RAM of N_WORDS x W with synchronous write and registered read.
- The FSM, order checker and counters stay in the top module.

Test Plan:
- Tree model holds 128 words 0..127, always non-empty, start pulse, rd_ready=1:
  - t_deq high for exactly 128 consecutive cycles.
  - STREAM emits 0..127 in order; rd_last on value 127.
  - done=1; order_err=0.
- Tree model inserts t_empty=1 for 5 cycles after each 16 pops:
  - t_deq is low during every empty cycle.
  - word_cnt reaches 128 after 128+7*5 cycles.
  - Output is identical to the previous scenario.
- Input with word 50 = 0x10 following word 49 = 0x20; further inversion at word 90:
  - order_err=1; err_idx=50 (first violation kept).
  - All 128 words are still streamed.
- rd_ready toggled randomly (≈50%) during STREAM:
  - rd_data stable while stalled.
  - Exactly 128 transfers; no duplicates or drops; rd_last only on the 128th.
- rst asserted at word_cnt=60, then released and start reissued with a fresh 128-word tree:
  - Outputs at reset values immediately on rst.
  - Second job completes correctly with order_err=0.
- start pulsed during COLLECT and again during STREAM:
  - No effect: word_cnt is not cleared and the stream sequence is unchanged.
  - An extra tree model holding 130 words sees only 128 pops.
